// File: rtl/tlc_pkg.sv
// tlc_pkg: shared traffic-light constants and width helper
package tlc_pkg;
  localparam int SYS_CLK_HZ = 100_000_000;
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/one_hz_divider_if.sv
// one_hz_divider_if: strobe bus; sec_count present only with ONEHZ_SECONDS_EN
interface one_hz_divider_if;
  logic oneHz_enable;
`ifdef ONEHZ_SECONDS_EN
  logic [7:0] sec_count;
  modport master (output oneHz_enable, output sec_count);
  modport slave (input oneHz_enable, input sec_count);
`else
  modport master (output oneHz_enable);
  modport slave (input oneHz_enable);
`endif
endinterface

// File: rtl/mod_counter.sv
// mod_counter: async active-low reset counter 0..MOD-1 with wrap flag
module mod_counter
  import tlc_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic clk,
  input  logic rst,
  output logic wrap_o
);
  localparam int W = clog2_min1(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    wrap_o = (cnt_q == LAST);
    cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/one_hz_divider.sv
// one_hz_divider: registered 1-cycle enable strobe every CLK_FREQ_HZ/TICK_HZ clocks
// ONEHZ_SECONDS_EN adds an 8-bit wrapping strobe counter on sec_count
module one_hz_divider
  import tlc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int TICK_HZ     = 1
) (
  input logic             clk,
  input logic             rst,
  one_hz_divider_if.master bus
);
  localparam int DIV = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
  if (DIV == 0) begin : g_bad_div
    $error("one_hz_divider: DIV must be >= 1 (check TICK_HZ/CLK_FREQ_HZ)");
  end
  logic wrap;
  logic en_q, en_d;
  mod_counter #(.MOD(DIV > 0 ? DIV : 1)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .wrap_o (wrap)
  );
  always_comb en_d = wrap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) en_q <= 1'b0;
    else      en_q <= en_d;
  assign bus.oneHz_enable = en_q;
`ifdef ONEHZ_SECONDS_EN
  logic [7:0] sec_q, sec_d;
  always_comb sec_d = wrap ? sec_q + 8'd1 : sec_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sec_q <= '0;
    else      sec_q <= sec_d;
  assign bus.sec_count = sec_q;
`endif
endmodule

// File: tb/tb_one_hz_divider.sv
// tb_one_hz_divider: directed checks for DIV=10 and DIV=1 divider instances
module tb_one_hz_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int strobes;
  one_hz_divider_if bus10 ();
  one_hz_divider_if bus1 ();
  one_hz_divider #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );
  one_hz_divider #(.CLK_FREQ_HZ(1), .TICK_HZ(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #1;
    check("rst_en_t1", bus10.oneHz_enable, 0);
    check("rst_en1_t1", bus1.oneHz_enable, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_en_clk", bus10.oneHz_enable, 0);
      check("rst_en1_clk", bus1.oneHz_enable, 0);
`ifdef ONEHZ_SECONDS_EN
      check("rst_sec", bus10.sec_count, 0);
`endif
    end
    release_rst();
    strobes = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("period_en", bus10.oneHz_enable, (k % 10 == 0) ? 1 : 0);
      check("div1_en", bus1.oneHz_enable, 1);
      strobes += bus10.oneHz_enable ? 1 : 0;
    end
    check("strobe_cnt", strobes, 10);
    rst = 1'b0;
    #1;
    check("mid_rst_en", bus10.oneHz_enable, 0);
    release_rst();
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b0;
    #1;
    check("mid5_rst_en", bus10.oneHz_enable, 0);
    release_rst();
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("re_release_en", bus10.oneHz_enable, (k == 10) ? 1 : 0);
    end
    check("pre_strobe_rst", bus10.oneHz_enable, 1);
    rst = 1'b0;
    #1;
    check("strobe_rst_en", bus10.oneHz_enable, 0);
    check("strobe_rst_en1", bus1.oneHz_enable, 0);
    release_rst();
    tick();
    check("div1_first_edge", bus1.oneHz_enable, 1);
    check("after_strobe_rst", bus10.oneHz_enable, 0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      check("restart_en", bus10.oneHz_enable, (k == 10) ? 1 : 0);
    end
`ifdef ONEHZ_SECONDS_EN
    rst = 1'b0;
    #1;
    check("sec_rst", bus10.sec_count, 0);
    release_rst();
    for (int k = 1; k <= 2600; k++) begin
      tick();
      if (k == 10) check("sec_first", bus10.sec_count, 1);
      if (k == 2550) check("sec_255", bus10.sec_count, 255);
      if (k == 2560) check("sec_wrap", bus10.sec_count, 0);
      if (k == 2600) check("sec_260", bus10.sec_count, 4);
      if (k % 10 == 0) check("sec_en", bus10.oneHz_enable, 1);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
